// File: rtl/mdu_div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): restoring shift-subtract, one quotient bit per cycle.
// Optional early-out for trivial operands when MDU_DIV_EARLY_OUT_EN is defined.
module mdu_div_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [4:0]            rd_addr,
  input  logic                  flush,
  output logic                  busy,
  output logic                  wr_en,
  output logic [4:0]            addr_wr,
  output logic [DATA_WIDTH-1:0] data_wr
);

  typedef enum logic [1:0] {StIdle, StPrep, StCalc, StDone} state_e;

  state_e                state_q;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [4:0]            rd_q;
  logic                  q_neg_q;
  logic                  r_neg_q;
  logic                  div_zero_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic                  signed_op;
  logic [DATA_WIDTH-1:0] a_abs;
  logic [DATA_WIDTH-1:0] b_abs;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] quo_fix;
  logic [DATA_WIDTH-1:0] rem_fix;
  logic [DATA_WIDTH-1:0] result;
  logic                  early;
  logic [DATA_WIDTH-1:0] early_quo;
  logic [DATA_WIDTH-1:0] early_rem;

`ifdef MDU_DIV_EARLY_OUT_EN
  localparam logic [DATA_WIDTH-1:0] MostNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

  always_comb begin
    signed_op = ~op_q[0];
    a_abs     = (signed_op && a_q[DATA_WIDTH-1]) ? -a_q : a_q;
    b_abs     = (signed_op && b_q[DATA_WIDTH-1]) ? -b_q : b_q;
    // Trial subtraction is one bit wider than the remainder; its MSB is the borrow.
    shifted   = {rem_q, quo_q[DATA_WIDTH-1]};
    diff      = shifted - {1'b0, b_q};
    // A zero divisor already yields all ones, which is the required quotient in both signednesses.
    quo_fix   = (q_neg_q && !div_zero_q) ? -quo_q : quo_q;
    rem_fix   = r_neg_q ? -rem_q : rem_q;
    result    = op_q[1] ? rem_fix : quo_fix;

    early     = 1'b0;
    early_quo = '0;
    early_rem = '0;
`ifdef MDU_DIV_EARLY_OUT_EN
    if (b_abs == '0) begin
      early     = 1'b1;
      early_quo = '1;
      early_rem = a_abs;
    end else if (signed_op && a_q == MostNeg && b_q == '1) begin
      early     = 1'b1;
      early_quo = a_abs;
    end else if (a_abs < b_abs) begin
      early     = 1'b1;
      early_rem = a_abs;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      rd_q       <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      wr_en      <= 1'b0;
      addr_wr    <= '0;
      data_wr    <= '0;
    end else begin
      wr_en <= 1'b0;
      if (flush) begin
        state_q <= StIdle;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              op_q    <= op;
              a_q     <= rs1_data;
              b_q     <= rs2_data;
              rd_q    <= rd_addr;
              busy    <= 1'b1;
              state_q <= StPrep;
            end
          end
          StPrep: begin
            q_neg_q    <= signed_op & (a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1]);
            r_neg_q    <= signed_op & a_q[DATA_WIDTH-1];
            div_zero_q <= (b_abs == '0);
            b_q        <= b_abs;
            cnt_q      <= CNT_WIDTH'(DATA_WIDTH);
            if (early) begin
              quo_q   <= early_quo;
              rem_q   <= early_rem;
              state_q <= StDone;
            end else begin
              quo_q   <= a_abs;
              rem_q   <= '0;
              state_q <= StCalc;
            end
          end
          StCalc: begin
            if (diff[DATA_WIDTH]) begin
              rem_q <= shifted[DATA_WIDTH-1:0];
              quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
              rem_q <= diff[DATA_WIDTH-1:0];
              quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b1};
            end
            cnt_q <= cnt_q - CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(1)) state_q <= StDone;
          end
          StDone: begin
            data_wr <= result;
            addr_wr <= rd_q;
            wr_en   <= (rd_q != 5'd0);
            busy    <= 1'b0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_div_unit.sv
// Scoreboard bench for mdu_div_unit: random and directed divides checked against an arithmetic model.
module tb_mdu_div_unit;

  localparam logic [1:0] OpDiv  = 2'b00;
  localparam logic [1:0] OpDivu = 2'b01;
  localparam logic [1:0] OpRem  = 2'b10;
  localparam logic [1:0] OpRemu = 2'b11;

`ifdef MDU_DIV_EARLY_OUT_EN
  localparam bit EarlyEn = 1'b1;
`else
  localparam bit EarlyEn = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op    = '0;
  logic [31:0] rs1   = '0;
  logic [31:0] rs2   = '0;
  logic [4:0]  rd    = '0;
  logic        busy;
  logic        wr_en;
  logic [4:0]  addr_wr;
  logic [31:0] data_wr;

  mdu_div_unit #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs1_data (rs1),
    .rs2_data (rs2),
    .rd_addr  (rd),
    .flush    (flush),
    .busy     (busy),
    .wr_en    (wr_en),
    .addr_wr  (addr_wr),
    .data_wr  (data_wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, got, want, cyc);
  endtask

  // RISC-V M-extension division semantics, straight from the ISA rules.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    int sa;
    int sb;
    if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
      sa = a;
      sb = b;
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic int latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma;
    logic [31:0] mb;
    bit          trivial;
    ma = (!o[0] && a[31]) ? (32'h0 - a) : a;
    mb = (!o[0] && b[31]) ? (32'h0 - b) : b;
    trivial = (b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (ma < mb);
    return (EarlyEn && trivial) ? 2 : 34;
  endfunction

  // Drives a request just after an edge; returns the index of the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input bit track, output int t);
    op    = o;
    rs1   = a;
    rs2   = b;
    rd    = r;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t     = cyc;
    if (track && r != 5'd0) exp_q.push_back('{t + latency(o, a, b), r, model(o, a, b)});
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r);
    int t;
    issue(o, a, b, r, 1'b1, t);
    chk("busy_after_accept", busy, 1);
    wait_until(t + latency(o, a, b));
    chk("busy_after_done", busy, 0);
  endtask

  // Monitor: every write must land exactly on its expected cycle with the expected payload.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      chk("wr_en", wr_en, 1);
      chk("addr_wr", addr_wr, mon_e.addr);
      chk("data_wr", data_wr, mon_e.data);
    end else if (wr_en) begin
      chk("spurious_wr_en", wr_en, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t;
    int          cnt;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rr;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_addr_wr", addr_wr, 0);
    chk("reset_data_wr", data_wr, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed corner cases, issued back to back.
    run_op(OpDiv,  32'hFFFF_FFF9, 32'd2, 5'd5);
    run_op(OpRem,  32'hFFFF_FFF9, 32'd2, 5'd5);
    run_op(OpDivu, 32'h1234_5678, 32'd0, 5'd1);
    run_op(OpRemu, 32'h1234_5678, 32'd0, 5'd2);
    run_op(OpDiv,  32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    run_op(OpRem,  32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    run_op(OpDiv,  32'd3, 32'hFFFF_FFF6, 5'd12);
    run_op(OpRem,  32'hFFFF_FFF6, 32'd0, 5'd13);

    // rd=0: full busy window, no write; a start during busy is dropped.
    issue(OpDivu, 32'd100, 32'd7, 5'd0, 1'b1, t);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy) cnt++;
      if (k == 10) begin
        op    = OpDivu;
        rs1   = 32'd50;
        rs2   = 32'd5;
        rd    = 5'd9;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("busy_cycles_rd0", cnt, 34);
    run_op(OpDivu, 32'd100, 32'd7, 5'd10);
    run_op(OpRemu, 32'd100, 32'd7, 5'd11);

    // Flush mid-CALC, then flush overriding a start in IDLE.
    issue(OpDivu, 32'd100, 32'd7, 5'd6, 1'b0, t);
    wait_until(t + 11);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("busy_after_flush", busy, 0);
    flush = 1'b1;
    issue(OpDivu, 32'd5, 32'd1, 5'd8, 1'b0, t);
    flush = 1'b0;
    chk("busy_flush_idle", busy, 0);
    run_op(OpDivu, 32'd100, 32'd7, 5'd3);

    // Asynchronous reset mid-CALC.
    issue(OpDiv, 32'hDEAD_BEEF, 32'd77, 5'd7, 1'b0, t);
    wait_until(t + 15);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr_wr", addr_wr, 0);
    chk("rst_data_wr", data_wr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(OpDiv, 32'hDEAD_BEEF, 32'd77, 5'd7);

    // Randomized traffic with biased corner operands.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      rr = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 20));
        2: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        3: ra = 32'($urandom_range(0, 50));
        default: ;
      endcase
      run_op(ro, ra, rb, rr);
    end

    wait_until(cyc + 5);
    chk("pending_writes", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
